pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//   Parametrised fetch-stage program-counter generator: holds the PC, advances it, and selects the next PC.
//   Next-PC sources: sequential +4, EX-stage redirect (branch/jump resolve), trap vector, and a return-address-stack (RAS) prediction.
//   Sits between the hazard unit (stall), the EX stage (redirect), the trap logic, and the instruction memory address port.
// PARAMETERS
//   XLEN       32          PC / address width in bits (>= 8)
//   RESET_VEC  32'h0       PC value loaded while reset_n is low
//   RAS_DEPTH  4           return-address-stack entries (power of 2, >= 2)
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous, active-low reset
//   stall          in   1      hazard-unit fetch stall (stallF): hold PC
//   redirect_valid in   1      EX resolved a taken branch/jump or a misprediction
//   redirect_pc    in   XLEN   target for redirect_valid
//   redirect_flush in   1      with redirect_valid: clear the RAS (speculation unwound)
//   trap_valid     in   1      trap/exception entry
//   trap_pc        in   XLEN   trap vector
//   call_f         in   1      predecode: instruction at pc is a call (jal/jalr with rd=x1/x5)
//   ret_f          in   1      predecode: instruction at pc is a return (jalr x0,0(x1/x5))
//   pc             out  XLEN   current fetch PC (registered)
//   pc_plus4       out  XLEN   pc + 4, combinational, wraps modulo 2^XLEN
//   ras_empty      out  1      RAS holds no valid entry (combinational from count)
//   misalign       out  1      registered one-cycle pulse: last loaded target had bits [1:0] != 0
// BEHAVIOUR
//   Reset (reset_n=0, async): pc=RESET_VEC, misalign=0, RAS count=0, RAS pointer=0; ras_empty=1.
//   Each rising edge with reset_n=1, next pc chosen by strict priority:
//     1. trap_valid                      -> pc <= {trap_pc[XLEN-1:2],2'b00}
//     2. redirect_valid                  -> pc <= {redirect_pc[XLEN-1:2],2'b00}
//     3. stall                           -> pc holds
//     4. ret_f && !ras_empty             -> pc <= RAS top (pop)
//     5. otherwise                       -> pc <= pc_plus4
//   Trap and redirect override stall; stall never blocks a redirect.
//   misalign <= 1 for one cycle iff case 1 or 2 fired and the chosen target[1:0] != 0; otherwise 0.
//   Latency: every source appears on pc exactly one cycle after its request edge.
//   RAS (updated only in cases 4/5; frozen under stall, trap, redirect):
//     push on call_f: write pc_plus4 at ptr+1, ptr++, count=min(count+1,RAS_DEPTH).
//     full push: circular overwrite of the oldest entry; count stays RAS_DEPTH.
//     pop on ret_f (count>0): ptr--, count--; pc takes the popped entry.
//     ret_f with empty RAS: no pop; case 5 (pc+4); EX redirect corrects later.
//     call_f && ret_f same cycle: pop supplies next pc, then push pc_plus4 into the same slot (net count unchanged).
//     redirect_flush with redirect_valid: count <= 0 (ptr unchanged); trap also clears count.
//   Pointer arithmetic is modulo RAS_DEPTH; pc_plus4 wraps at 2^XLEN with no flag.
//   Reset asserted mid-stall/mid-redirect: async reset wins immediately; no pending request survives.
// STRUCTURE
//   Shared package pc_pkg: localparams PC_INC=4, IALIGN_BITS=2; next-PC source select enum
//     (SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ) for use by debug/trace.
//   One sub-module: pc_ras (circular stack; ports push, pop, push_data, flush, top, empty);
//     pc_gen holds the PC register, priority mux and misalign flag.
// TESTING
//   Reset: reset_n=0 with RESET_VEC=32'h100 -> pc=0x100, ras_empty=1, misalign=0; release -> pc 0x104 next edge.
//   Stall vs redirect: stall=1 with redirect_valid=1, redirect_pc=0x200 -> pc=0x200 next cycle; stall alone holds pc 3 cycles.
//   Trap priority: trap_valid (0x80) + redirect_valid (0x300) same edge -> pc=0x80, RAS count=0.
//   Call/return: call_f at pc=0x10 -> pc=0x14, top=0x14; later ret_f at 0x40 -> pc=0x14, ras_empty=1.
//   RAS overflow: 5 calls with RAS_DEPTH=4 (pcs 0x0,0x10,0x20,0x30,0x40) -> 4 rets return 0x44,0x34,0x24,0x14; 5th ret -> pc+4.
//   Misalign: redirect_pc=0x203 -> pc=0x200, misalign=1 for exactly one cycle; call_f+ret_f same cycle keeps count.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC generator.
// The source enum is also intended for debug/trace consumers.
package pc_pkg;

   localparam int unsigned PC_INC      = 4;
   localparam int unsigned IALIGN_BITS = 2;

   typedef enum logic [2:0] {
      SEL_TRAP,
      SEL_REDIR,
      SEL_HOLD,
      SEL_RAS,
      SEL_SEQ
   } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: ptr names the top entry, count saturates at DEPTH
// so that an overflowing push silently overwrites the oldest return address.
module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   input  logic            flush,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] mem [DEPTH];

   logic            pop_ok;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;

   assign empty  = (count == '0);
   assign top    = mem[ptr];
   assign pop_ok = pop && !empty;

   // A simultaneous pop+push reuses the popped slot, leaving ptr and count untouched.
   always_comb begin
      wr_en  = push && !flush;
      wr_idx = pop_ok ? ptr : ptr + PW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr   <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (pop_ok && push) begin
         ptr   <= ptr;
         count <= count;
      end else if (pop_ok) begin
         ptr   <= ptr - PW'(1);
         count <= count - CW'(1);
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (count != CW'(DEPTH))
            count <= count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: strict-priority next-PC select (trap, redirect,
// stall, RAS prediction, sequential) with a one-cycle misaligned-target flag.
module pc_gen #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_flush,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            call_f,
   input  logic            ret_f,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            ras_empty,
   output logic            misalign
);

   import pc_pkg::*;

   function automatic logic [XLEN-1:0] align_tgt(input logic [XLEN-1:0] a);
      return {a[XLEN-1:IALIGN_BITS], {IALIGN_BITS{1'b0}}};
   endfunction

   function automatic logic is_misaligned(input logic [XLEN-1:0] a);
      return |a[IALIGN_BITS-1:0];
   endfunction

   pc_sel_e         sel;
   logic [XLEN-1:0] pc_next;
   logic            tgt_mis;
   logic [XLEN-1:0] ras_top;
   logic            ras_push;
   logic            ras_pop;
   logic            ras_flush;

   assign pc_plus4 = pc + XLEN'(PC_INC);

   always_comb begin
      sel = SEL_SEQ;
      if (trap_valid)
         sel = SEL_TRAP;
      else if (redirect_valid)
         sel = SEL_REDIR;
      else if (stall)
         sel = SEL_HOLD;
      else if (ret_f && !ras_empty)
         sel = SEL_RAS;
   end

   always_comb begin
      pc_next = pc_plus4;
      tgt_mis = 1'b0;
      unique case (sel)
         SEL_TRAP: begin
            pc_next = align_tgt(trap_pc);
            tgt_mis = is_misaligned(trap_pc);
         end
         SEL_REDIR: begin
            pc_next = align_tgt(redirect_pc);
            tgt_mis = is_misaligned(redirect_pc);
         end
         SEL_HOLD: pc_next = pc;
         SEL_RAS:  pc_next = ras_top;
         default:  pc_next = pc_plus4;
      endcase
   end

   // The stack only moves when fetch actually advances down the predicted path.
   assign ras_pop   = (sel == SEL_RAS);
   assign ras_push  = call_f && ((sel == SEL_SEQ) || (sel == SEL_RAS));
   assign ras_flush = trap_valid || (redirect_valid && redirect_flush);

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus4),
      .flush     (ras_flush),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_VEC;
         misalign <= 1'b0;
      end else begin
         pc       <= pc_next;
         misalign <= tgt_mis;
      end
   end

endmodule
